// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, load/store port and the shared memory port.
// The arbiter connects through the slave modport; the CPU/memory side uses master.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;

  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_mask;
  logic [31:0] ls_rdata;
  logic        ls_valid;

  logic        mem_request;
  logic        mem_re_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        err;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_valid, if_stall,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_mask,
    output ls_rdata, ls_valid,
    output mem_request, mem_re_we, mem_mask, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output err
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_valid, if_stall,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_mask,
    input  ls_rdata, ls_valid,
    input  mem_request, mem_re_we, mem_mask, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto a single-outstanding memory port,
// with alternating priority under contention and a bounded wait for mem_ack.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT  = 15,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int DATA_W = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IF_BUSY = 2'd1;
  localparam logic [1:0] ST_LS_BUSY = 2'd2;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_LS = 1'b1;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0]        state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              err_q, err_d;

  logic              mem_re_we_q, mem_re_we_d;
  logic [3:0]        mem_mask_q, mem_mask_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              ls_valid_q, ls_valid_d;

  logic              grant_ls;
  logic              grant_if;
  logic              wait_expired;

  // LS wins when alone, or when both ask and fetch was served last.
  function automatic logic pick_ls(input logic if_req, input logic ls_req,
                                   input logic last_grant);
    return ls_req && (!if_req || (last_grant == GRANT_IF));
  endfunction

  always_comb begin
    grant_ls     = 1'b0;
    grant_if     = 1'b0;
    wait_expired = (wait_cnt_q == WAIT_LAST);

    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    mem_re_we_d  = mem_re_we_q;
    mem_mask_d   = mem_mask_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    if_valid_d   = 1'b0;
    ls_rdata_d   = ls_rdata_q;
    ls_valid_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The requester still holds req during its valid cycle, so no grant then.
        if (!(if_valid_q || ls_valid_q)) begin
          grant_ls = pick_ls(bus.if_req, bus.ls_req, last_grant_q);
          grant_if = bus.if_req && !grant_ls;
        end
        if (grant_ls) begin
          state_d      = ST_LS_BUSY;
          wait_cnt_d   = 8'd0;
          last_grant_d = GRANT_LS;
          mem_re_we_d  = bus.ls_we;
          mem_mask_d   = bus.ls_mask;
          mem_addr_d   = bus.ls_addr;
          mem_wdata_d  = bus.ls_wdata;
        end else if (grant_if) begin
          state_d      = ST_IF_BUSY;
          wait_cnt_d   = 8'd0;
          last_grant_d = GRANT_IF;
          mem_re_we_d  = 1'b0;
          mem_mask_d   = 4'b1111;
          mem_addr_d   = bus.if_addr;
          mem_wdata_d  = '0;
        end
      end

      ST_IF_BUSY: begin
        if (bus.mem_ack) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 8'd0;
          if_rdata_d = bus.mem_rdata;
          if_valid_d = 1'b1;
        end else if (wait_expired) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 8'd0;
          if_rdata_d = NOP_INSTR;
          if_valid_d = 1'b1;
          err_d      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      ST_LS_BUSY: begin
        if (bus.mem_ack) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 8'd0;
          ls_valid_d = 1'b1;
          if (!mem_re_we_q) begin
            ls_rdata_d = bus.mem_rdata;
          end
        end else if (wait_expired) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 8'd0;
          ls_rdata_d = '0;
          ls_valid_d = 1'b1;
          err_d      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 8'd0;
      last_grant_q <= GRANT_IF;
      err_q        <= 1'b0;
      mem_re_we_q  <= 1'b0;
      mem_mask_q   <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      if_valid_q   <= 1'b0;
      ls_rdata_q   <= '0;
      ls_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      mem_re_we_q  <= mem_re_we_d;
      mem_mask_q   <= mem_mask_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      if_valid_q   <= if_valid_d;
      ls_rdata_q   <= ls_rdata_d;
      ls_valid_q   <= ls_valid_d;
    end
  end

  // mem_request decodes the state flop so it falls with an asynchronous reset.
  assign bus.mem_request = (state_q == ST_IF_BUSY) || (state_q == ST_LS_BUSY);
  assign bus.mem_re_we   = mem_re_we_q;
  assign bus.mem_mask    = mem_mask_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_stall    = bus.if_req && !if_valid_q;
  assign bus.ls_rdata    = ls_rdata_q;
  assign bus.ls_valid    = ls_valid_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MAX_WAIT=4): fetch, contention, timeout, idle ack, resets.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] ex_addr  [6];
  logic [31:0] ex_wdata [6];
  logic [3:0]  ex_mask  [6];
  logic        ex_we    [6];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = 0;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = 0; bus.ls_wdata = 0; bus.ls_mask = 0;
    bus.mem_rdata = 0; bus.mem_ack = 0;

    // Contention table: even = LS, odd = IF
    ex_addr[0] = 32'h2000; ex_wdata[0] = 32'hDEADBEEF; ex_mask[0] = 4'b0011; ex_we[0] = 1'b1;
    ex_addr[1] = 32'h0104; ex_wdata[1] = 32'h0;        ex_mask[1] = 4'hF;    ex_we[1] = 1'b0;
    ex_addr[2] = 32'h2004; ex_wdata[2] = 32'h0;        ex_mask[2] = 4'hF;    ex_we[2] = 1'b0;
    ex_addr[3] = 32'h0108; ex_wdata[3] = 32'h0;        ex_mask[3] = 4'hF;    ex_we[3] = 1'b0;
    ex_addr[4] = 32'h2008; ex_wdata[4] = 32'h0;        ex_mask[4] = 4'hF;    ex_we[4] = 1'b0;
    ex_addr[5] = 32'h010C; ex_wdata[5] = 32'h0;        ex_mask[5] = 4'hF;    ex_we[5] = 1'b0;

    #1 rst = 1'b0;
    #2;
    chk("rst_mem_request", 32'(bus.mem_request), 32'd0);
    chk("rst_if_valid",    32'(bus.if_valid),    32'd0);
    chk("rst_ls_valid",    32'(bus.ls_valid),    32'd0);
    chk("rst_err",         32'(bus.err),         32'd0);
    chk("rst_mem_addr",    bus.mem_addr,         32'd0);
    chk("rst_if_rdata",    bus.if_rdata,         32'd0);

    // Single fetch, ack in the second busy cycle
    #20;
    rst = 1'b1;
    bus.if_req = 1; bus.if_addr = 32'h100;
    cyc();
    chk("f_mem_request", 32'(bus.mem_request), 32'd1);
    chk("f_mem_addr",    bus.mem_addr,         32'h100);
    chk("f_mem_mask",    32'(bus.mem_mask),    32'hF);
    chk("f_mem_re_we",   32'(bus.mem_re_we),   32'd0);
    chk("f_mem_wdata",   bus.mem_wdata,        32'd0);
    chk("f_if_stall",    32'(bus.if_stall),    32'd1);
    cyc();
    chk("f_busy2_valid", 32'(bus.if_valid),    32'd0);
    bus.mem_ack = 1; bus.mem_rdata = 32'h00500093;
    cyc();
    chk("f_if_valid",    32'(bus.if_valid),    32'd1);
    chk("f_if_rdata",    bus.if_rdata,         32'h00500093);
    chk("f_done_req",    32'(bus.mem_request), 32'd0);
    chk("f_stall_clr",   32'(bus.if_stall),    32'd0);
    bus.mem_ack = 0; bus.if_req = 0;
    cyc();
    chk("f_valid_pulse", 32'(bus.if_valid),    32'd0);
    chk("f_rdata_hold",  bus.if_rdata,         32'h00500093);

    // Ack while idle is ignored
    bus.mem_ack = 1; bus.mem_rdata = 32'hFFFFFFFF;
    cyc();
    chk("idle_ack_ifv",  32'(bus.if_valid),    32'd0);
    chk("idle_ack_lsv",  32'(bus.ls_valid),    32'd0);
    chk("idle_ack_req",  32'(bus.mem_request), 32'd0);
    chk("idle_ack_rd",   bus.if_rdata,         32'h00500093);
    bus.mem_ack = 0;

    // Fresh reset, then continuous contention: LS, IF, LS, IF, LS, IF
    rst = 1'b0;
    #2 rst = 1'b1;
    bus.ls_req = 1; bus.ls_we = ex_we[0]; bus.ls_addr = ex_addr[0];
    bus.ls_wdata = ex_wdata[0]; bus.ls_mask = ex_mask[0];
    bus.if_req = 1; bus.if_addr = ex_addr[1];
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("c%0d_req", k),   32'(bus.mem_request), 32'd1);
      chk($sformatf("c%0d_we", k),    32'(bus.mem_re_we),   32'(ex_we[k]));
      chk($sformatf("c%0d_addr", k),  bus.mem_addr,         ex_addr[k]);
      chk($sformatf("c%0d_mask", k),  32'(bus.mem_mask),    32'(ex_mask[k]));
      chk($sformatf("c%0d_wdata", k), bus.mem_wdata,        ex_wdata[k]);
      bus.mem_ack = 1; bus.mem_rdata = 32'hA0000000 + k;
      cyc();
      chk($sformatf("c%0d_ls_valid", k), 32'(bus.ls_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("c%0d_if_valid", k), 32'(bus.if_valid), (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k == 0)
        chk("c0_store_ls_rdata", bus.ls_rdata, 32'd0);
      else if (k % 2 == 0)
        chk($sformatf("c%0d_ls_rdata", k), bus.ls_rdata, 32'hA0000000 + k);
      else
        chk($sformatf("c%0d_if_rdata", k), bus.if_rdata, 32'hA0000000 + k);
      bus.mem_ack = 0;
      if (k + 2 < 6) begin
        if (k % 2 == 0) begin
          bus.ls_we = ex_we[k+2]; bus.ls_addr = ex_addr[k+2];
          bus.ls_wdata = ex_wdata[k+2]; bus.ls_mask = ex_mask[k+2];
        end else begin
          bus.if_addr = ex_addr[k+2];
        end
      end
      cyc();
      chk($sformatf("c%0d_gap", k), 32'(bus.mem_request), 32'd0);
    end
    bus.if_req = 0; bus.ls_req = 0;
    cyc();

    // Fetch timeout after 4 busy cycles
    bus.if_req = 1; bus.if_addr = 32'h200;
    cyc();
    chk("to_if_req",   32'(bus.mem_request), 32'd1);
    chk("to_err_pre",  32'(bus.err),         32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("to_if_wait%0d", i), 32'({bus.mem_request, bus.if_valid}), 32'b10);
    end
    cyc();
    chk("to_if_valid", 32'(bus.if_valid),    32'd1);
    chk("to_if_nop",   bus.if_rdata,         32'h00000013);
    chk("to_if_err",   32'(bus.err),         32'd1);
    chk("to_if_idle",  32'(bus.mem_request), 32'd0);
    bus.if_req = 0;
    cyc();
    chk("to_if_pulse", 32'(bus.if_valid),    32'd0);
    chk("to_err_hold", 32'(bus.err),         32'd1);

    // Load timeout zeroes ls_rdata
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h4000; bus.ls_mask = 4'hF;
    cyc();
    chk("to_ls_addr",  bus.mem_addr,         32'h4000);
    for (int i = 0; i < 3; i++) cyc();
    cyc();
    chk("to_ls_valid", 32'(bus.ls_valid),    32'd1);
    chk("to_ls_rdata", bus.ls_rdata,         32'd0);
    chk("to_ls_err",   32'(bus.err),         32'd1);
    bus.ls_req = 0;
    cyc();

    // Requester drops req mid-transaction; completion still reported
    bus.if_req = 1; bus.if_addr = 32'h300;
    cyc();
    chk("drop_req",    32'(bus.mem_request), 32'd1);
    bus.if_req = 0;
    cyc();
    bus.mem_ack = 1; bus.mem_rdata = 32'h0BADCAFE;
    cyc();
    chk("drop_valid",  32'(bus.if_valid),    32'd1);
    chk("drop_rdata",  bus.if_rdata,         32'h0BADCAFE);
    bus.mem_ack = 0;
    cyc();

    // Asynchronous reset during a store
    bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 32'h5000; bus.ls_wdata = 32'h55; bus.ls_mask = 4'hF;
    cyc();
    chk("ar_busy",     32'(bus.mem_request), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_req_drop", 32'(bus.mem_request), 32'd0);
    chk("ar_ls_valid", 32'(bus.ls_valid),    32'd0);
    chk("ar_err",      32'(bus.err),         32'd0);
    chk("ar_addr",     bus.mem_addr,         32'd0);
    bus.ls_req = 0; bus.mem_ack = 1;
    cyc();
    chk("ar_hold_lsv", 32'(bus.ls_valid),    32'd0);
    bus.mem_ack = 0;
    rst = 1'b1;
    cyc();
    chk("ar_post_lsv", 32'(bus.ls_valid),    32'd0);
    chk("ar_post_req", 32'(bus.mem_request), 32'd0);
    chk("ar_post_err", 32'(bus.err),         32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter MAX_WAIT, default 15: bus-cycle limit waiting for mem_ack before timeout (1..255).
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h00000013: instruction returned to fetch on timeout.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 if_req  in  1  fetch read request, held until if_valid.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_rdata  out  32  fetched instruction, registered.
REQ-008 if_valid  out  1  one-cycle pulse: if_rdata valid.
REQ-009 if_stall  out  1  fetch must hold PC.
REQ-010 ls_req  in  1  load/store request, held until ls_valid.
REQ-011 ls_we  in  1  1 = store, 0 = load.
REQ-012 ls_addr, ls_wdata  in  32 each  load/store address, store data.
REQ-013 ls_mask  in  4  byte enables.
REQ-014 ls_rdata  out  32  load data, registered.
REQ-015 ls_valid  out  1  one-cycle pulse: load/store complete.
REQ-016 mem_request  out  1  memory transaction active.
REQ-017 mem_re_we  out  1  0 = read, 1 = write.
REQ-018 mem_mask  out  4  byte enables to memory.
REQ-019 mem_addr, mem_wdata  out  32 each  memory address, write data.
REQ-020 mem_rdata  in  32  memory read data, valid with mem_ack.
REQ-021 mem_ack  in  1  memory completes current transaction this cycle.
REQ-022 err  out  1  sticky timeout flag.

Function
REQ-023 SHALL implement FSM states IDLE, IF_BUSY, LS_BUSY.
REQ-024 IDLE, only ls_req: latch ls_addr/ls_wdata/ls_mask/ls_we into mem_* registers, go LS_BUSY.
REQ-025 IDLE, only if_req: latch if_addr, mem_mask=4'b1111, mem_re_we=0, mem_wdata=0, go IF_BUSY.
REQ-026 IDLE, both requests: grant the requester not served last (last_grant bit); after reset, LS wins first.
REQ-027 mem_request SHALL be 1 exactly in IF_BUSY/LS_BUSY; mem_* outputs registered and stable throughout the transaction.
REQ-028 Latency: request sampled at edge N -> mem_request high from cycle N+1; mem_ack at cycle M (M>=N+1) -> valid pulse and rdata in cycle M+1, state IDLE in M+1.
REQ-029 On mem_ack in IF_BUSY: if_rdata<=mem_rdata, if_valid pulse; in LS_BUSY: ls_rdata<=mem_rdata (loads; unchanged on stores), ls_valid pulse.
REQ-030 New grant earliest in cycle after valid pulse (one IDLE cycle minimum between transactions).
REQ-031 mem_ack in IDLE SHALL be ignored.
REQ-032 8-bit wait counter clears on entering BUSY, increments each BUSY cycle without ack; reaching MAX_WAIT: return to IDLE, pulse owning valid, if_rdata=NOP_INSTR or ls_rdata=0, set err.
REQ-033 err SHALL stay 1 until reset.
REQ-034 if_stall = if_req AND NOT if_valid (combinational).
REQ-035 Requester dropping req mid-transaction: transaction completes normally, valid still pulsed; no abort.
REQ-036 last_grant updates on every grant.

Reset
REQ-037 rst low: FSM IDLE, all outputs 0, counter 0, err 0, last_grant = IF (LS favoured next), immediately and asynchronously.
REQ-038 rst asserted mid-transaction: transaction abandoned, no valid pulse; mem_request drops without waiting for clk.

Verification
REQ-039 if_req=1, if_addr=0x100, mem_ack 2 cycles after mem_request, mem_rdata=0x00500093 -> mem_mask=4'hF, mem_re_we=0, if_valid one cycle with if_rdata=0x00500093.
REQ-040 if_req and ls_req (store, addr 0x2000, wdata 0xDEADBEEF, mask 4'b0011) same cycle after reset -> store issued first (mem_re_we=1), then fetch; next contention grants fetch.
REQ-041 Continuous contention over 6 transactions -> grants alternate LS, IF, LS, IF, LS, IF.
REQ-042 MAX_WAIT=4, never ack fetch -> if_valid at 4th busy cycle edge, if_rdata=0x00000013, err=1 and stays 1.
REQ-043 rst low during LS_BUSY -> mem_request 0 without clock edge, no ls_valid, err 0.
REQ-044 mem_ack pulsed while IDLE -> no valid pulse, state unchanged.
